weight_winograd_xform: RTL and testbench

- Sits directly downstream of the weight controller/buffer and directly upstream of the PE arrays.
- Accepts one 18-word weight fetch: two 3x3 kernels, A (od1) and B (od2).
- Computes the integer-scaled Winograd F(2x2,3x3) kernel transform U' = (2G)·g·(2G)^T = 4·U for each kernel, serially A then B, through a 2-stage row/column pipeline.
- Presents each 4x4 result through a valid/ready output slot. The PE array removes the scale of 4.

---
 rtl/weight_winograd_xform.sv | 166 ++++++++++++++++
 tb/tb_weight_winograd_xform.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_winograd_xform.sv
// Winograd F(2x2,3x3) weight transform, scaled by 4: U' = (2G) g (2G)^T.
// Captures one 18-word fetch (kernels A and B) and transforms A then B through
// a row stage (t_q) and a column stage (output slot). Each 4x4 tile is presented
// through a valid/ready slot that can reload on the same edge it is consumed.
module weight_winograd_xform #(
   parameter  int DATA_W = 16,
   localparam int OUT_W  = DATA_W + 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic signed [DATA_W-1:0] weight_data_i [18],
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic signed [OUT_W-1:0]  out_u_o [16],
   output logic                     out_kernel_o,
   output logic                     out_last_o,
   output logic [7:0]               xform_count_o
);

   // Row-stage width: a sum of three weights needs two extra bits.
   localparam int T_W = DATA_W + 2;

   typedef enum logic [2:0] {IDLE, ROW_A, COL_A, ROW_B, COL_B} state_t;

   state_t                  state_q, state_d;
   logic signed [DATA_W-1:0] cap_q [18];
   logic signed [DATA_W-1:0] cap_d [18];
   logic signed [T_W-1:0]    t_q [12];
   logic signed [T_W-1:0]    t_d [12];
   logic signed [OUT_W-1:0]  u_q [16];
   logic signed [OUT_W-1:0]  u_d [16];
   logic                     out_valid_q, out_valid_d;
   logic                     out_kernel_q, out_kernel_d;
   logic                     out_last_q, out_last_d;
   logic [7:0]               count_q, count_d;

   logic                     kernel_b;
   logic                     xfer;
   logic                     slot_free;
   logic signed [T_W-1:0]    row_t [12];
   logic signed [OUT_W-1:0]  col_u [16];

   function automatic logic signed [T_W-1:0] sx_t(input logic signed [DATA_W-1:0] v);
      return {{(T_W-DATA_W){v[DATA_W-1]}}, v};
   endfunction

   function automatic logic signed [OUT_W-1:0] sx_u(input logic signed [T_W-1:0] v);
      return {{(OUT_W-T_W){v[T_W-1]}}, v};
   endfunction

   assign kernel_b  = (state_q == ROW_B);
   assign xfer      = out_valid_q && out_ready_i;
   assign slot_free = !out_valid_q || out_ready_i;

   // Row transform of the selected kernel; t index is 3*row + column.
   for (genvar gi = 0; gi < 3; gi++) begin : g_row
      logic signed [T_W-1:0] g0, g1, g2;
      assign g0 = sx_t(kernel_b ? cap_q[9 + gi] : cap_q[gi]);
      assign g1 = sx_t(kernel_b ? cap_q[12 + gi] : cap_q[3 + gi]);
      assign g2 = sx_t(kernel_b ? cap_q[15 + gi] : cap_q[6 + gi]);
      assign row_t[gi]     = g0 + g0;
      assign row_t[3 + gi] = g0 + g1 + g2;
      assign row_t[6 + gi] = g0 - g1 + g2;
      assign row_t[9 + gi] = g2 + g2;
   end

   // Column transform of the held row result; u index is 4*row + column.
   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic signed [OUT_W-1:0] t0, t1, t2;
      assign t0 = sx_u(t_q[3*gi]);
      assign t1 = sx_u(t_q[3*gi + 1]);
      assign t2 = sx_u(t_q[3*gi + 2]);
      assign col_u[4*gi]     = t0 + t0;
      assign col_u[4*gi + 1] = t0 + t1 + t2;
      assign col_u[4*gi + 2] = t0 - t1 + t2;
      assign col_u[4*gi + 3] = t2 + t2;
   end

   // Next-state, capture, pipeline and output-slot logic.
   always_comb begin
      state_d      = state_q;
      cap_d        = cap_q;
      t_d          = t_q;
      u_d          = u_q;
      out_valid_d  = out_valid_q;
      out_kernel_d = out_kernel_q;
      out_last_d   = out_last_q;
      count_d      = count_q;
      in_ready_o   = 1'b0;

      // A consumed tile empties the slot unless a COL state reloads it below.
      if (xfer) begin
         out_valid_d = 1'b0;
         count_d     = count_q + 8'd1;
      end

      case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               cap_d   = weight_data_i;
               state_d = ROW_A;
            end
         end
         ROW_A: begin
            t_d     = row_t;
            state_d = COL_A;
         end
         COL_A: begin
            if (slot_free) begin
               u_d          = col_u;
               out_valid_d  = 1'b1;
               out_kernel_d = 1'b0;
               out_last_d   = 1'b0;
               state_d      = ROW_B;
            end
         end
         ROW_B: begin
            t_d     = row_t;
            state_d = COL_B;
         end
         COL_B: begin
            if (slot_free) begin
               u_d          = col_u;
               out_valid_d  = 1'b1;
               out_kernel_d = 1'b1;
               out_last_d   = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         for (int i = 0; i < 18; i++) cap_q[i] <= '0;
         for (int i = 0; i < 12; i++) t_q[i] <= '0;
         for (int i = 0; i < 16; i++) u_q[i] <= '0;
         out_valid_q  <= 1'b0;
         out_kernel_q <= 1'b0;
         out_last_q   <= 1'b0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         cap_q        <= cap_d;
         t_q          <= t_d;
         u_q          <= u_d;
         out_valid_q  <= out_valid_d;
         out_kernel_q <= out_kernel_d;
         out_last_q   <= out_last_d;
         count_q      <= count_d;
      end
   end

   assign out_valid_o   = out_valid_q;
   assign out_u_o       = u_q;
   assign out_kernel_o  = out_kernel_q;
   assign out_last_o    = out_last_q;
   assign xform_count_o = count_q;

endmodule

// File: tb/tb_weight_winograd_xform.sv
// Self-checking bench for weight_winograd_xform: matrix-product reference model,
// a scoreboard checked on every output transfer, and directed literal checks.
module tb_weight_winograd_xform;

   localparam int DATA_W = 16;
   localparam int OUT_W  = DATA_W + 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic in_ready, out_valid, out_kernel, out_last;
   logic [7:0] cnt;
   logic signed [DATA_W-1:0] wd [18];
   logic signed [OUT_W-1:0]  out_u [16];

   always #5 clk = ~clk;

   weight_winograd_xform dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .weight_data_i (wd),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_u_o       (out_u),
      .out_kernel_o  (out_kernel),
      .out_last_o    (out_last),
      .xform_count_o (cnt)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Reference: U' = (2G) g (2G)^T by plain matrix products.
   function automatic void xform(input int g [9], output int u [16]);
      int g2 [12];
      int tmp [12];
      g2 = '{2, 0, 0, 1, 1, 1, 1, -1, 1, 0, 0, 2};
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 3; j++) begin
            tmp[3*i+j] = 0;
            for (int k = 0; k < 3; k++) tmp[3*i+j] += g2[3*i+k] * g[3*k+j];
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            u[4*i+j] = 0;
            for (int k = 0; k < 3; k++) u[4*i+j] += tmp[3*i+k] * g2[3*j+k];
         end
   endfunction

   typedef struct packed {
      logic [15:0][OUT_W-1:0] u;
      logic                   k;
      logic                   last;
   } tile_t;

   tile_t exp_q [$];
   int    exp_count = 0;

   task automatic push_fetch();
      int ga [9], gb [9], ua [16], ub [16];
      tile_t t;
      for (int k = 0; k < 9; k++) begin
         ga[k] = int'(wd[k]);
         gb[k] = int'(wd[9+k]);
      end
      xform(ga, ua);
      xform(gb, ub);
      for (int i = 0; i < 16; i++) t.u[i] = ua[i][OUT_W-1:0];
      t.k = 1'b0; t.last = 1'b0;
      exp_q.push_back(t);
      for (int i = 0; i < 16; i++) t.u[i] = ub[i][OUT_W-1:0];
      t.k = 1'b1; t.last = 1'b1;
      exp_q.push_back(t);
   endtask

   // Compare process: every cycle, away from the rising edge.
   logic                   stall_prev = 1'b0;
   logic [15:0][OUT_W-1:0] prev_u;
   logic                   prev_k, prev_l;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         exp_count  = 0;
         stall_prev = 1'b0;
      end else begin
         check("xform_count", cnt, exp_count % 256);
         if (stall_prev) begin
            logic same;
            same = out_valid && (out_kernel == prev_k) && (out_last == prev_l);
            for (int i = 0; i < 16; i++) if (out_u[i] != prev_u[i]) same = 1'b0;
            check("stall_hold", same, 1);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_tile", 1, 0);
            end else begin
               tile_t e;
               e = exp_q.pop_front();
               for (int i = 0; i < 16; i++)
                  check($sformatf("tile_u[%0d]", i), int'(out_u[i]), int'($signed(e.u[i])));
               check("tile_kernel", out_kernel, e.k);
               check("tile_last", out_last, e.last);
            end
            exp_count++;
         end
         stall_prev = out_valid && !out_ready;
         for (int i = 0; i < 16; i++) prev_u[i] = out_u[i];
         prev_k = out_kernel;
         prev_l = out_last;
         if (in_valid && in_ready) push_fetch();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic signed [DATA_W-1:0] rw();
      case ($urandom_range(0, 9))
         0:       return 16'sh7fff;
         1:       return 16'sh8000;
         default: return DATA_W'($urandom);
      endcase
   endfunction

   task automatic rand_fetch();
      for (int k = 0; k < 18; k++) wd[k] = rw();
   endtask

   task automatic start_fetch();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int g [9];
      int u [16];
      int lit_a [16];
      int lit_b [16];
      int base;
      int n;
      int last_c;
      logic acc;

      lit_a = '{4, 6, 2, 4, 6, 9, 3, 6, 2, 3, 1, 2, 4, 6, 2, 4};
      lit_b = '{0, 0, 0, 0, 0, 1, -1, 0, 0, -1, 1, 0, 0, 0, 0, 0};

      // Pin the reference model with hand-derived values.
      for (int k = 0; k < 9; k++) g[k] = 1;
      xform(g, u);
      for (int i = 0; i < 16; i++) check("model_ones", u[i], lit_a[i]);
      for (int k = 0; k < 9; k++) g[k] = 0;
      g[4] = 1;
      xform(g, u);
      for (int i = 0; i < 16; i++) check("model_center", u[i], lit_b[i]);
      for (int k = 0; k < 9; k++) g[k] = -32768;
      xform(g, u);
      check("model_min_11", u[5], -294912);

      for (int k = 0; k < 18; k++) wd[k] = '0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state.
      check("rst_out_valid", out_valid, 0);
      check("rst_count", cnt, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_kernel", out_kernel, 0);
      check("rst_last", out_last, 0);
      for (int i = 0; i < 16; i++) check("rst_u", int'(out_u[i]), 0);

      // Kernel A all ones, kernel B centre tap only.
      for (int k = 0; k < 9; k++) wd[k] = 16'sd1;
      for (int k = 9; k < 18; k++) wd[k] = 16'sd0;
      wd[13] = 16'sd1;
      out_ready = 1'b1;
      start_fetch();                       // E0
      tick();                              // E1
      check("lat_a_not_yet", out_valid, 0);
      check("busy_in_ready", in_ready, 0);
      tick();                              // E2
      check("lat_a_valid", out_valid, 1);
      for (int i = 0; i < 16; i++) check("ones_u", int'(out_u[i]), lit_a[i]);
      check("ones_kernel", out_kernel, 0);
      check("ones_last", out_last, 0);
      tick();                              // E3
      tick();                              // E4
      check("lat_b_valid", out_valid, 1);
      for (int i = 0; i < 16; i++) check("center_u", int'(out_u[i]), lit_b[i]);
      check("center_kernel", out_kernel, 1);
      check("center_last", out_last, 1);
      tick();                              // E5
      check("count_after_two", cnt, 2);

      // Extreme values.
      for (int k = 0; k < 9; k++) wd[k] = 16'sh7fff;
      for (int k = 9; k < 18; k++) wd[k] = 16'sh8000;
      start_fetch();
      tick();
      tick();
      check("max_u11", int'(out_u[5]), 294903);
      tick();
      tick();
      check("min_u11", int'(out_u[5]), -294912);
      check("min_u00", int'(out_u[0]), -131072);
      tick();

      // Backpressure: tile A held, B reloads on the release edge.
      rand_fetch();
      out_ready = 1'b0;
      start_fetch();
      tick();
      tick();
      check("bp_a_valid", out_valid, 1);
      repeat (10) tick();
      check("bp_a_still", out_valid, 1);
      check("bp_a_kernel", out_kernel, 0);
      out_ready = 1'b1;
      tick();
      check("bp_b_valid", out_valid, 1);
      check("bp_b_kernel", out_kernel, 1);
      check("bp_b_last", out_last, 1);
      tick();
      check("bp_drained", out_valid, 0);

      // Reset while stalled in COL_A with tile B of the previous fetch waiting.
      rand_fetch();
      out_ready = 1'b0;
      start_fetch();                       // E0
      tick(); tick(); tick();              // A held, parked in COL_B
      out_ready = 1'b1;
      tick();                              // A out, B in, back to IDLE
      out_ready = 1'b0;
      rand_fetch();
      start_fetch();                       // accepted while B waits
      tick(); tick();                      // stalled in COL_A
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_count", cnt, 0);
      check("mid_rst_kernel", out_kernel, 0);
      check("mid_rst_last", out_last, 0);
      for (int i = 0; i < 16; i++) check("mid_rst_u", int'(out_u[i]), 0);
      tick();
      reset = 1'b0;
      check("mid_rst_ready", in_ready, 1);
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         check("no_tile_after_rst", out_valid, 0);
      end

      // Streaming: three fetches back-to-back with ready tied high.
      base = cnt;
      rand_fetch();
      in_valid = 1'b1;
      n = 0;
      last_c = 0;
      for (int c = 0; c < 40 && n < 3; c++) begin
         acc = in_ready;
         tick();
         if (acc) begin
            n++;
            if (n > 1) check("stream_gap", c - last_c, 5);
            last_c = c;
            rand_fetch();
         end
      end
      in_valid = 1'b0;
      check("stream_accepts", n, 3);
      repeat (10) tick();
      check("stream_count", cnt, (base + 6) % 256);

      // Random traffic with random backpressure.
      for (int c = 0; c < 400; c++) begin
         if (!in_valid && $urandom_range(0, 2) == 0) begin
            rand_fetch();
            in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 3) != 0);
         acc = in_valid && in_ready;
         tick();
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (20) tick();
      check("drain_empty", exp_q.size(), 0);
      check("final_idle_ready", in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
